// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch with run/pause/clear and optional lap hold
// Optional feature: define STOPWATCH_LAP_EN to include the LAP display-hold state.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_go,
   input  logic       btn_clr,
   input  logic       btn_lap,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic       running,
   output logic       lap_active,
   output logic       tick,
   output logic       rollover
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_LAP   = 2'd3;
`ifdef STOPWATCH_LAP_EN
   localparam logic [1:0] LAP_TGT  = ST_LAP;
`else
   localparam logic [1:0] LAP_TGT  = ST_RUN;
`endif

   logic [1:0]    state_q, state_d;
   logic          btn_go_q, btn_clr_q, btn_lap_q;
   logic          armed_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    isec_q, isec_d, imin_q, imin_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic          running_q, running_d, lap_active_q, lap_active_d;
   logic          tick_q, tick_d, rollover_q, rollover_d;
   logic          go_edge, clr_edge, lap_edge, run_now;

   // armed_q masks edges in the first cycle after reset so a held button is not seen as pressed
   assign go_edge  = btn_go  & ~btn_go_q  & armed_q;
   assign clr_edge = btn_clr & ~btn_clr_q & armed_q;
   assign lap_edge = btn_lap & ~btn_lap_q & armed_q;
   assign run_now  = (state_q == ST_RUN) || (state_q == ST_LAP);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (go_edge) state_d = ST_RUN;
         ST_RUN:   if (go_edge) state_d = ST_PAUSE;
                   else if (lap_edge) state_d = LAP_TGT;
         ST_PAUSE: if (clr_edge) state_d = ST_IDLE;
                   else if (go_edge) state_d = ST_RUN;
`ifdef STOPWATCH_LAP_EN
         ST_LAP:   if (go_edge) state_d = ST_PAUSE;
                   else if (lap_edge) state_d = ST_RUN;
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      presc_d    = presc_q;
      isec_d     = isec_q;
      imin_d     = imin_q;
      rollover_d = 1'b0;
      tick_d     = run_now && (presc_q == PRESC_MAX);
      if (run_now) begin
         if (tick_d) begin
            presc_d = '0;
            if (isec_q == 6'd59) begin
               isec_d = 6'd0;
               if (imin_q == 6'd59) begin
                  imin_d     = 6'd0;
                  rollover_d = 1'b1;
               end else begin
                  imin_d = imin_q + 6'd1;
               end
            end else begin
               isec_d = isec_q + 6'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      if (state_d == ST_IDLE) begin
         presc_d = '0;
         isec_d  = 6'd0;
         imin_d  = 6'd0;
      end
   end

   always_comb begin
      running_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_active_d = (state_d == ST_LAP);
      sec_d        = isec_d;
      min_d        = imin_d;
`ifdef STOPWATCH_LAP_EN
      // entering or staying in LAP freezes the display at the value shown at the lap edge
      if (state_d == ST_LAP) begin
         sec_d = sec_q;
         min_d = min_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         btn_go_q     <= 1'b0;
         btn_clr_q    <= 1'b0;
         btn_lap_q    <= 1'b0;
         armed_q      <= 1'b0;
         presc_q      <= '0;
         isec_q       <= 6'd0;
         imin_q       <= 6'd0;
         sec_q        <= 6'd0;
         min_q        <= 6'd0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         tick_q       <= 1'b0;
         rollover_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         btn_go_q     <= btn_go;
         btn_clr_q    <= btn_clr;
         btn_lap_q    <= btn_lap;
         armed_q      <= 1'b1;
         presc_q      <= presc_d;
         isec_q       <= isec_d;
         imin_q       <= imin_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
         tick_q       <= tick_d;
         rollover_q   <= rollover_d;
      end
   end

   assign sec        = sec_q;
   assign min        = min_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign tick       = tick_q;
   assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed scoreboard bench for stopwatch_ctrl at TICK_DIV=4
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_go = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
   logic [5:0] sec, min;
   logic       running, lap_active, tick, rollover;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .btn_go(btn_go), .btn_clr(btn_clr), .btn_lap(btn_lap),
      .sec(sec), .min(min), .running(running), .lap_active(lap_active),
      .tick(tick), .rollover(rollover)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input int n);
      repeat (n) step();
   endtask

   task automatic push(input string tag, input logic [5:0] m, input logic [5:0] s,
                       input logic r, input logic l, input logic t, input logic ro);
      exp_t e;
      e.tag = tag;
      e.v   = {m, s, r, l, t, ro};
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [15:0] obs;
      obs = {min, sec, running, lap_active, tick, rollover};
      n_checks++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) n_pass++;
         else $error("FAIL %s: observed min=%0d sec=%0d run=%b lap=%b tick=%b roll=%b required min=%0d sec=%0d run=%b lap=%b tick=%b roll=%b",
                     e.tag, obs[15:10], obs[9:4], obs[3], obs[2], obs[1], obs[0],
                     e.v[15:10], e.v[9:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
   endtask

   // fresh reset then a go edge; RUN entered at the returned edge with prescaler 0
   task automatic start_run();
      reset = 1'b1; btn_go = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
      cyc(2);
      reset = 1'b0;
      step();
      btn_go = 1'b1;
      step();
      btn_go = 1'b0;
   endtask

   initial begin
      cyc(3);
      push("reset_state", 6'd0, 6'd0, 0, 0, 0, 0); check();
      reset = 1'b0;
      cyc(2);
      push("idle_quiet", 6'd0, 6'd0, 0, 0, 0, 0); check();

      btn_go = 1'b1;
      push("go_running", 6'd0, 6'd0, 1, 0, 0, 0);
      step(); check();
      btn_go = 1'b0;
      push("before_first_tick", 6'd0, 6'd0, 1, 0, 0, 0);
      cyc(3); check();
      push("first_tick", 6'd0, 6'd1, 1, 0, 1, 0);
      step(); check();
      push("tick_one_cycle", 6'd0, 6'd1, 1, 0, 0, 0);
      step(); check();

      // prescaler is 1 here; the pausing edge leaves it held at 2
      btn_go = 1'b1;
      push("pause", 6'd0, 6'd1, 0, 0, 0, 0);
      step(); check();
      btn_go = 1'b0;
      push("pause_hold", 6'd0, 6'd1, 0, 0, 0, 0);
      cyc(5); check();
      btn_go = 1'b1;
      push("resume", 6'd0, 6'd1, 1, 0, 0, 0);
      step(); check();
      btn_go = 1'b0;
      push("resume_cycle1", 6'd0, 6'd1, 1, 0, 0, 0);
      step(); check();
      push("resume_cycle2_tick", 6'd0, 6'd2, 1, 0, 1, 0);
      step(); check();

      btn_clr = 1'b1;
      push("clr_ignored_run", 6'd0, 6'd2, 1, 0, 0, 0);
      step(); check();
      btn_clr = 1'b0;
      btn_go  = 1'b1;
      push("pause_again", 6'd0, 6'd2, 0, 0, 0, 0);
      step(); check();
      btn_go = 1'b0;
      step();
      btn_go  = 1'b1;
      btn_clr = 1'b1;
      push("clr_over_go", 6'd0, 6'd0, 0, 0, 0, 0);
      step(); check();
      btn_go  = 1'b0;
      btn_clr = 1'b0;
      push("idle_after_clr", 6'd0, 6'd0, 0, 0, 0, 0);
      cyc(2); check();

      // long run: tick n lands 4n edges after the go edge
      start_run();
      push("at_00_59", 6'd0, 6'd59, 1, 0, 0, 0);
      cyc(239); check();
      push("min_carry", 6'd1, 6'd0, 1, 0, 1, 0);
      step(); check();
      push("at_59_59_tick", 6'd59, 6'd59, 1, 0, 1, 0);
      cyc(14156); check();
      push("at_59_59_hold", 6'd59, 6'd59, 1, 0, 0, 0);
      cyc(3); check();
      push("rollover_pulse", 6'd0, 6'd0, 1, 0, 1, 1);
      step(); check();
      push("rollover_end", 6'd0, 6'd0, 1, 0, 0, 0);
      step(); check();

      start_run();
      push("lap_prep_00_05", 6'd0, 6'd5, 1, 0, 1, 0);
      cyc(20); check();
      btn_lap = 1'b1;
      push("lap_enter", 6'd0, 6'd5, 1, LAP_ON, 0, 0);
      step(); check();
      btn_lap = 1'b0;
      push("lap_hold_at_08", 6'd0, LAP_ON ? 6'd5 : 6'd8, 1, LAP_ON, 1, 0);
      cyc(11); check();
      btn_lap = 1'b1;
      push("lap_release", 6'd0, 6'd8, 1, 0, 0, 0);
      step(); check();
      btn_lap = 1'b0;
      step();
      btn_go  = 1'b1;
      btn_lap = 1'b1;
      push("go_over_lap", 6'd0, 6'd8, 0, 0, 0, 0);
      step(); check();
      btn_go  = 1'b0;
      btn_lap = 1'b0;
      step();
      btn_lap = 1'b1;
      push("lap_ignored_pause", 6'd0, 6'd8, 0, 0, 0, 0);
      step(); check();
      btn_lap = 1'b0;

      start_run();
      cyc(13);
      reset  = 1'b1;
      btn_go = 1'b1;
      push("reset_mid_second", 6'd0, 6'd0, 0, 0, 0, 0);
      step(); check();
      reset = 1'b0;
      push("held_go_no_edge", 6'd0, 6'd0, 0, 0, 0, 0);
      cyc(3); check();
      btn_go = 1'b0;
      step();
      btn_go = 1'b1;
      push("go_after_release", 6'd0, 6'd0, 1, 0, 0, 0);
      step(); check();
      btn_go = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, giving clock cycles per one-second tick (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port btn_go  input  1  synchronous level; each rising edge toggles run/pause.
REQ-005 SHALL have port btn_clr  input  1  synchronous level; a rising edge clears the time.
REQ-006 SHALL have port btn_lap  input  1  synchronous level; a rising edge toggles the lap hold.
REQ-007 SHALL have port sec  output  6  displayed seconds, 0..59.
REQ-008 SHALL have port min  output  6  displayed minutes, 0..59.
REQ-009 SHALL have port running  output  1  high in RUN or LAP.
REQ-010 SHALL have port lap_active  output  1  high in LAP.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each internal seconds increment.
REQ-012 SHALL have port rollover  output  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

Function
REQ-013 SHALL register each button; an edge pulse is asserted in the cycle where btn=1 and the registered copy=0.
REQ-014 SHALL act on an edge pulse at the next clk edge, giving 1-cycle latency from first sampled high to state change.
REQ-015 SHALL implement states IDLE, RUN, PAUSE and LAP; all outputs are registered.
REQ-016 SHALL transition IDLE->RUN on go, RUN->PAUSE on go, PAUSE->RUN on go, PAUSE->IDLE on clr, RUN->LAP on lap, LAP->RUN on lap and LAP->PAUSE on go.
REQ-017 SHALL ignore clr in RUN and LAP, and ignore lap outside RUN and LAP.
REQ-018 SHALL give go priority over lap when both edges occur in the same cycle in RUN or LAP.
REQ-019 SHALL give clr priority over go when both edges occur in the same cycle in PAUSE.
REQ-020 SHALL run the prescaler 0..TICK_DIV-1 only in RUN or LAP, and hold its value in PAUSE so a resumed second keeps its elapsed fraction.
REQ-021 SHALL zero the prescaler and the internal sec/min on entry to IDLE.
REQ-022 SHALL, when the prescaler equals TICK_DIV-1 in RUN or LAP, wrap the prescaler to 0, pulse tick and increment the internal seconds at the same edge.
REQ-023 SHALL wrap seconds 59->0 and increment minutes in the same cycle.
REQ-024 SHALL, at 59:59 with a tick, go to 00:00, pulse rollover and stay in RUN or LAP.
REQ-025 SHALL drive sec/min from the internal count in every state except LAP.

Reset
REQ-026 SHALL, on reset, enter IDLE and zero the prescaler, internal time, button registers, sec, min, running, lap_active, tick and rollover.
REQ-027 SHALL let reset override all other inputs, including during RUN or LAP and in the middle of a second.
REQ-028 SHALL not detect an edge in the first cycle after reset if a button is already high.

Configuration
REQ-029 SHALL, with macro STOPWATCH_LAP_EN defined, include the LAP state: sec/min hold the value captured at the lap edge while the internal count continues.
REQ-030 SHALL, with STOPWATCH_LAP_EN undefined, omit the LAP state, ignore btn_lap, tie lap_active to 0 and drive sec/min from the internal count at all times.

Verification (TICK_DIV=4)
REQ-031 SHALL cover: reset, then a go edge -> running=1 one cycle later; tick and sec=1 after 4 running cycles.
REQ-032 SHALL cover: run at 00:59, then a tick -> sec=0, min=1, rollover=0.
REQ-033 SHALL cover: run at 59:59, then a tick -> 00:00, a one-cycle rollover pulse, running=1.
REQ-034 SHALL cover: go edge at prescaler=2 (pause), then go again -> tick exactly 2 running cycles after resume; a clr edge in PAUSE -> 00:00, IDLE, running=0.
REQ-035 SHALL cover (STOPWATCH_LAP_EN): lap edge at 00:05 -> display holds 00:05 through internal 00:08; a second lap edge -> display 00:08 next cycle, lap_active=0.
REQ-036 SHALL cover: reset asserted at 00:03 in RUN with the prescaler at 1 -> all outputs 0 and IDLE next cycle; btn_go held high through reset -> no edge detected.
